// File: rtl/branch_redirect.sv
// branch_redirect: architectural PC and redirect controller for the mips32
// pipeline. Consumes the ID-stage branch decision, picks the next fetch
// address, defers redirects that arrive during a hazard stall, and issues a
// one-cycle IF/ID flush plus link information for every committed redirect.
module branch_redirect #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             stall,
  input  logic             is_branch,
  input  logic [2:0]       code,
  input  logic [1:0]       jsel,
  input  logic [31:0]      branch_target,
  input  logic [31:0]      jump_target,
  input  logic [31:0]      jr_target,
  output logic [31:0]      pc,
  output logic [31:0]      pc_plus4,
  output logic             flush_ifid,
  output logic             link_valid,
  output logic [31:0]      link_addr,
  output logic             addr_error,
  output logic [CNT_W-1:0] taken_count
);

  typedef enum logic [0:0] {RUN, PEND} state_t;

  localparam logic [2:0] CODE_JUMP = 3'b101;
  localparam logic [1:0] JSEL_JAL  = 2'b01;
  localparam logic [1:0] JSEL_JR   = 2'b10;

  state_t           state, state_next;
  logic [31:0]      pc_next;
  logic [31:0]      pend_target, pend_target_next;
  logic             pend_jal, pend_jal_next;
  logic [31:0]      pend_link, pend_link_next;
  logic             flush_next, link_valid_next, addr_error_next;
  logic [31:0]      link_addr_next;
  logic [CNT_W-1:0] taken_count_next;

  logic        valid_code, is_jump, req_jal, req, misaligned, accept;
  logic [31:0] target;
  logic        commit, commit_jal;
  logic [31:0] commit_target, commit_link;

  assign pc_plus4 = pc + 32'd4;

  // Decode the ID-stage decision into a cycle-local redirect request.
  always_comb begin
    valid_code = (code >= 3'b001) && (code <= CODE_JUMP);
    is_jump    = (code == CODE_JUMP);
    req_jal    = is_jump && (jsel == JSEL_JAL);
    if (!is_jump)             target = branch_target;
    else if (jsel == JSEL_JR) target = jr_target;
    else                      target = jump_target;
    // A decision seen while the flush pulse is high is from a wrong-path slot.
    req        = is_branch && valid_code && !flush_ifid && (state == RUN);
    misaligned = |target[1:0];
    accept     = req && !misaligned;
  end

  // Next-state and next-output logic for the RUN/PEND controller.
  always_comb begin
    // NOTE: every signal gets a default before any branch so no path leaves
    // it unassigned; otherwise synthesis would infer a latch to hold it.
    state_next       = state;
    pc_next          = pc;
    pend_target_next = pend_target;
    pend_jal_next    = pend_jal;
    pend_link_next   = pend_link;
    flush_next       = 1'b0;
    link_valid_next  = 1'b0;
    link_addr_next   = link_addr;
    addr_error_next  = 1'b0;
    taken_count_next = taken_count;
    commit           = 1'b0;
    commit_target    = pend_target;
    commit_jal       = pend_jal;
    commit_link      = pend_link;

    unique case (state)
      RUN: begin
        if (!stall) begin
          addr_error_next = req && misaligned;
          if (accept) begin
            commit        = 1'b1;
            commit_target = target;
            commit_jal    = req_jal;
            commit_link   = pc;
          end else begin
            pc_next = pc_plus4;
          end
        end else if (accept) begin
          // Stalled redirect: remember it and commit once the stall clears.
          pend_target_next = target;
          pend_jal_next    = req_jal;
          pend_link_next   = pc;
          state_next       = PEND;
        end
      end
      PEND: begin
        if (!stall) begin
          commit     = 1'b1;
          state_next = RUN;
        end
      end
    endcase

    if (commit) begin
      pc_next         = commit_target;
      flush_next      = 1'b1;
      link_valid_next = commit_jal;
      if (commit_jal) link_addr_next = commit_link;
      if (!(&taken_count)) taken_count_next = taken_count + CNT_W'(1);
    end
  end

  // State and output registers; reset may arrive at any time, including PEND.
  always_ff @(posedge clock or negedge reset_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!reset_n) begin
      state       <= RUN;
      pc          <= RESET_PC;
      pend_target <= '0;
      pend_jal    <= 1'b0;
      pend_link   <= '0;
      flush_ifid  <= 1'b0;
      link_valid  <= 1'b0;
      link_addr   <= '0;
      addr_error  <= 1'b0;
      taken_count <= '0;
    end else begin
      state       <= state_next;
      pc          <= pc_next;
      pend_target <= pend_target_next;
      pend_jal    <= pend_jal_next;
      pend_link   <= pend_link_next;
      flush_ifid  <= flush_next;
      link_valid  <= link_valid_next;
      link_addr   <= link_addr_next;
      addr_error  <= addr_error_next;
      taken_count <= taken_count_next;
    end
  end

endmodule

// File: doc/branch_redirect.md
# branch_redirect

Program-counter and redirect controller for the mips32 pipeline; the consumer of the ID-stage branch decision (`is_branch` plus the 3-bit compare code). Holds the architectural PC, selects sequential, branch, or jump targets, honours hazard stalls, and carries a redirect taken during a stall until the stall clears. Issues a one-cycle IF/ID flush after every redirect. Keeps a saturating count of taken redirects for debug.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC value loaded at reset.
- `CNT_W`, default 16: width of `taken_count`.

Ports:
- `clock`  in  1  single clock, rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `stall`  in  1  hazard-unit stall; PC and pending state hold while high.
- `is_branch`  in  1  ID-stage decision: take the control transfer.
- `code`  in  3  compare code: 000 none, 001 beq, 010 bne, 011 bgt, 100 ble, 101 j/jal/jr.
- `jsel`  in  2  valid when code=101: 00 j, 01 jal, 10 jr, 11 reserved (treated as j).
- `branch_target`  in  32  PC-relative target for codes 001–100.
- `jump_target`  in  32  absolute target for j/jal.
- `jr_target`  in  32  register value for jr.
- `pc`  out  32  current fetch address.
- `pc_plus4`  out  32  `pc + 4`, combinational from `pc`.
- `flush_ifid`  out  1  registered one-cycle pulse that clears the IF/ID register.
- `link_valid`  out  1  registered one-cycle pulse when a jal redirect commits.
- `link_addr`  out  32  return address: the ID-stage `pc_plus4` captured at jal acceptance (ID instruction address + 4 = `pc`). Held until the next jal.
- `addr_error`  out  1  registered one-cycle pulse: a taken target had bits [1:0] ≠ 0.
- `taken_count`  out  `CNT_W`  saturating count of committed redirects.

## Operation
- **Redirect request (cycle-local).** `req` is asserted when all of the following hold: `is_branch` = 1, `code` ∈ {001..101}, `flush_ifid` = 0, and state = RUN. Decisions presented while `flush_ifid` is high belong to a wrong-path instruction and are ignored.
- **Target selection.**
  - `code` 001–100: `branch_target`.
  - `code` 101, `jsel` = 10: `jr_target`.
  - `code` 101, any other `jsel`: `jump_target`.
- **Misaligned target.** If the selected target has bits [1:0] ≠ 0, the request is dropped. `addr_error` pulses the next cycle, PC continues sequentially, and no flush, count, or link is produced.
- **Codes 110 and 111** are treated as 000. `is_branch` with code 000 is ignored.
- **State machine: RUN, PEND.**
  - RUN, `stall` = 0, valid `req`:
    - `pc` ← target; `flush_ifid` ← 1; `taken_count` increments.
    - If the request is a jal: `link_valid` ← 1 and `link_addr` ← `pc` (the ID-stage jal's PC + 4).
  - RUN, `stall` = 0, no `req`: `pc` ← `pc` + 4 (wraps modulo 2^32).
  - RUN, `stall` = 1, valid `req`:
    - Latch `pend_target`, `pend_jal`, and `pend_link` ← `pc` (the ID-stage jal's PC + 4).
    - Go to PEND. `pc` holds. No flush yet.
  - RUN, `stall` = 1, no `req`: hold everything.
  - PEND, `stall` = 1: hold. New `is_branch` and `code` inputs are ignored (the stalled ID instruction repeats its decision).
  - PEND, `stall` = 0:
    - `pc` ← `pend_target`; `flush_ifid` ← 1; increment `taken_count`.
    - If `pend_jal`: `link_valid` ← 1 and `link_addr` ← `pend_link`.
    - Go to RUN.
- **Counter.** `taken_count` saturates at all-ones.
- **Reset (any time, including while in PEND).**
  - `pc` = `RESET_PC`; state = RUN.
  - `flush_ifid`, `link_valid`, `addr_error` = 0.
  - `link_addr`, `pend_*`, `taken_count` = 0.

## Timing
- Redirect latency: a decision in cycle N with `stall` low gives `pc` = target and `flush_ifid` = 1 in cycle N+1.
- `flush_ifid` is high for exactly one cycle per committed redirect. It is never asserted for a dropped request.
- Stalled redirect: the commit happens on the first edge where `stall` is low. `pc` = target and `flush_ifid` = 1 appear in the following cycle.
- Back-to-back: a decision in the cycle immediately after a redirect is masked by `flush_ifid`. The earliest next accepted redirect is cycle N+2.
- `pc_plus4` has zero latency relative to `pc`.
- All registered outputs change only on a `clock` rising edge or on `reset_n` falling.

## Test plan
- **Reset.** Release `reset_n` with `stall` = 0 and no decisions, `RESET_PC` = 0 → `pc` = 0, 4, 8, 12 on successive cycles; all pulse outputs stay 0.
- **Taken beq.** At `pc` = 0x10: `code` = 001, `is_branch` = 1, `branch_target` = 0x40 → next cycle `pc` = 0x40, `flush_ifid` = 1 for one cycle, `taken_count` = 1. A decision held high during the flush cycle is ignored, so the following cycle `pc` = 0x44.
- **Stalled jal.** `pc` = 0x20, `stall` = 1, `code` = 101, `jsel` = 01, `jump_target` = 0x100, held 3 cycles → `pc` holds 0x20 with no flush. Drop `stall` → next cycle `pc` = 0x100, `flush_ifid` = 1, `link_valid` = 1, `link_addr` = 0x20.
- **Misaligned jr.** `code` = 101, `jsel` = 10, `jr_target` = 0x0000_0102 → `addr_error` pulses, `pc` advances by 4, `taken_count` unchanged.
- **Reset in PEND.** Enter PEND with target 0x80, assert `reset_n` low mid-stall, release → `pc` = `RESET_PC`, and no redirect to 0x80 ever occurs.
- **Counter and PC wrap.** Force 2^`CNT_W` + 3 redirects → `taken_count` = 0xFFFF. Sequential fetch from `pc` = 0xFFFF_FFFC → next `pc` = 0.
